// File: rtl/indirect_access_ctrl.sv
// Indirect-access command controller: decodes command-register writes and sequences
// read/write/compare/reset/init strobes to a single register-file table under a grant handshake.
module indirect_access_ctrl #(
    parameter logic [10:0] CMND_ADDRESS = 11'h454,
    parameter int          N_ENTRIES    = 32,
    parameter int          N_DATA_BITS  = 32,
    parameter logic [15:0] CAPABILITIES = 16'h8027,
    parameter logic [3:0]  MEM_TYPE     = 4'h2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_stb,
    input  logic [10:0]                reg_addr,
    input  logic [3:0]                 cmnd_op,
    input  logic [$clog2(N_ENTRIES)-1:0] cmnd_addr,
    input  logic                       cmnd_table_id,
    input  logic [$clog2(N_ENTRIES)-1:0] addr_limit,
    input  logic [N_DATA_BITS-1:0]     wr_dat,
    input  logic [N_DATA_BITS-1:0]     sw_rdat,
    input  logic                       sw_match,
    input  logic [3:0]                 sw_aindex,
    input  logic                       grant,
    output logic [2:0]                 stat_code,
    output logic [4:0]                 stat_datawords,
    output logic [$clog2(N_ENTRIES)-1:0] stat_addr,
    output logic                       stat_table_id,
    output logic [15:0]                capability_lst,
    output logic [3:0]                 capability_type,
    output logic                       enable,
    output logic [N_DATA_BITS-1:0]     rd_dat,
    output logic                       sw_cs,
    output logic                       sw_ce,
    output logic                       sw_we,
    output logic [$clog2(N_ENTRIES)-1:0] sw_add,
    output logic [N_DATA_BITS-1:0]     sw_wdat,
    output logic                       yield,
    output logic                       reset
);
    localparam int AW = $clog2(N_ENTRIES);

    localparam logic [3:0] OP_NOP       = 4'd0;
    localparam logic [3:0] OP_READ      = 4'd1;
    localparam logic [3:0] OP_WRITE     = 4'd2;
    localparam logic [3:0] OP_ENABLE    = 4'd3;
    localparam logic [3:0] OP_DISABLE   = 4'd4;
    localparam logic [3:0] OP_RESET     = 4'd5;
    localparam logic [3:0] OP_INIT      = 4'd6;
    localparam logic [3:0] OP_INIT_INC  = 4'd7;
    localparam logic [3:0] OP_SET_START = 4'd8;
    localparam logic [3:0] OP_COMPARE   = 4'd9;
    localparam logic [3:0] OP_SIM_TMO   = 4'd14;
    localparam logic [3:0] OP_ACK_ERROR = 4'd15;

    typedef enum logic [3:0] {
        ST_POWERDOWN    = 4'd0,
        ST_READY        = 4'd1,
        ST_DO_WRITE     = 4'd2,
        ST_DO_READ      = 4'd3,
        ST_DO_COMPARE   = 4'd4,
        ST_DO_RESET     = 4'd5,
        ST_DO_INIT      = 4'd6,
        ST_COMPARE_WAIT = 4'd7,
        ST_READ_DONE    = 4'd8,
        ST_COMPARE_DONE = 4'd9,
        ST_ERROR        = 4'd10
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [2:0]             r_stat, w_stat_nxt;
    logic                   r_init, w_init_nxt;
    logic [N_DATA_BITS-1:0] r_rd_dat, w_rd_dat_nxt;
    logic                   r_cs, w_cs_nxt, r_ce, w_ce_nxt, r_we, w_we_nxt;
    logic                   r_rst, w_rst_nxt, r_rst_or_ini, w_rst_or_ini_nxt;
    logic                   r_timer, w_timer_nxt;
    logic [AW-1:0]          r_rst_addr, w_rst_addr_nxt;
    logic                   r_sim_tmo, w_sim_tmo_nxt;

    logic          w_dec, w_cmnd_issued, w_unsup, w_badaddr, w_igrant, w_timeout;
    logic [AW-1:0] w_maxaddr;
    logic          w_unused;

    assign w_dec         = wr_stb && (reg_addr == CMND_ADDRESS);
    assign w_cmnd_issued = w_dec && (cmnd_op != OP_NOP) && (cmnd_op != OP_SIM_TMO);
    assign w_unsup       = w_dec && (cmnd_op >= 4'd10) && (cmnd_op <= 4'd13);
    assign w_maxaddr     = r_init ? {AW{1'b0}} : addr_limit;
    assign w_badaddr     = w_cmnd_issued && (cmnd_addr > w_maxaddr);
    assign w_igrant      = grant && !r_sim_tmo;
    assign w_timeout     = (r_timer == 1'b1);
    assign w_unused      = cmnd_table_id;

    // Next-state, status, strobe and data-path decisions for the coming cycle.
    always_comb begin
        w_state_nxt      = r_state;
        w_stat_nxt       = r_stat;
        w_init_nxt       = r_init;
        w_rd_dat_nxt     = r_rd_dat;
        w_cs_nxt         = 1'b0;
        w_ce_nxt         = 1'b0;
        w_we_nxt         = 1'b0;
        w_rst_nxt        = 1'b0;
        w_rst_or_ini_nxt = 1'b0;
        w_timer_nxt      = 1'b0;
        w_rst_addr_nxt   = r_rst_addr;
        w_sim_tmo_nxt    = r_sim_tmo;

        if (w_timeout) begin
            w_sim_tmo_nxt = 1'b0;
        end else if (w_dec && (cmnd_op == OP_SIM_TMO)) begin
            w_sim_tmo_nxt = 1'b1;
        end else begin
            w_sim_tmo_nxt = r_sim_tmo;
        end

        case (r_state)
            ST_POWERDOWN: begin
                w_rd_dat_nxt = wr_dat;
                if (w_dec && (cmnd_op == OP_ENABLE)) begin
                    w_state_nxt = ST_READY;
                end else begin
                    w_state_nxt = ST_POWERDOWN;
                end
            end
            ST_READY: begin
                if (w_dec) begin
                    case (cmnd_op)
                        OP_WRITE:              w_state_nxt = ST_DO_WRITE;
                        OP_READ:               w_state_nxt = ST_DO_READ;
                        OP_COMPARE:            w_state_nxt = ST_DO_COMPARE;
                        OP_RESET:              w_state_nxt = ST_DO_RESET;
                        OP_INIT, OP_INIT_INC:  w_state_nxt = ST_DO_INIT;
                        OP_DISABLE:            w_state_nxt = ST_POWERDOWN;
                        OP_NOP, OP_ENABLE, OP_SET_START, OP_SIM_TMO, OP_ACK_ERROR:
                                               w_state_nxt = ST_READY;
                        default:               w_state_nxt = ST_ERROR;
                    endcase
                end else begin
                    w_state_nxt = ST_READY;
                end
            end
            ST_DO_WRITE:   w_state_nxt = w_igrant ? ST_READY : ST_DO_WRITE;
            ST_DO_READ:    w_state_nxt = w_igrant ? ST_READ_DONE : ST_DO_READ;
            ST_DO_COMPARE: w_state_nxt = w_igrant ? ST_COMPARE_WAIT : ST_DO_COMPARE;
            ST_DO_RESET:   w_state_nxt = ST_READY;
            ST_DO_INIT: begin
                w_rst_addr_nxt = r_rst_addr + {{(AW-1){1'b0}}, w_igrant};
                if (w_igrant && (r_rst_addr == cmnd_addr)) begin
                    w_state_nxt = ST_READY;
                end else begin
                    w_state_nxt = ST_DO_INIT;
                end
            end
            ST_COMPARE_WAIT: w_state_nxt = ST_COMPARE_DONE;
            ST_READ_DONE: begin
                w_rd_dat_nxt = sw_rdat;
                w_state_nxt  = ST_READY;
            end
            ST_COMPARE_DONE: begin
                w_rd_dat_nxt = {{(N_DATA_BITS-5){1'b0}}, sw_match, sw_aindex};
                w_state_nxt  = ST_READY;
            end
            ST_ERROR: begin
                if (w_dec && (cmnd_op == OP_ACK_ERROR)) begin
                    w_state_nxt = r_init ? ST_POWERDOWN : ST_READY;
                end else begin
                    w_state_nxt = ST_ERROR;
                end
            end
            default: w_state_nxt = ST_ERROR;
        endcase

        // An access in flight is abandoned on timeout or on any new command.
        if ((w_timeout || w_cmnd_issued) && (r_state != ST_POWERDOWN) &&
            (r_state != ST_READY) && (r_state != ST_ERROR)) begin
            w_state_nxt = ST_ERROR;
        end else begin
            w_state_nxt = w_state_nxt;
        end
        if (w_badaddr) begin
            w_state_nxt = ST_ERROR;
        end else begin
            w_state_nxt = w_state_nxt;
        end

        if (w_dec && (cmnd_op == OP_SET_START)) begin
            w_rst_addr_nxt = cmnd_addr;
        end else if (w_dec && (cmnd_op == OP_RESET)) begin
            w_rst_addr_nxt = {AW{1'b0}};
        end else begin
            w_rst_addr_nxt = w_rst_addr_nxt;
        end

        case (w_state_nxt)
            ST_POWERDOWN: begin
                w_stat_nxt = 3'd7;
                w_init_nxt = 1'b1;
            end
            ST_READY: begin
                w_stat_nxt = 3'd0;
                w_init_nxt = 1'b0;
            end
            ST_ERROR: begin
                if (r_state == ST_ERROR) begin
                    w_stat_nxt = r_stat;
                end else if (w_unsup) begin
                    w_stat_nxt = 3'd5;
                end else if (w_badaddr) begin
                    w_stat_nxt = 3'd4;
                end else if (w_timeout) begin
                    w_stat_nxt = 3'd2;
                end else if (w_cmnd_issued) begin
                    w_stat_nxt = 3'd3;
                end else begin
                    w_stat_nxt = r_stat;
                end
            end
            ST_DO_WRITE: begin
                w_stat_nxt  = 3'd1;
                w_cs_nxt    = 1'b1;
                w_we_nxt    = 1'b1;
                w_timer_nxt = r_timer + 1'b1;
            end
            ST_DO_READ: begin
                w_stat_nxt  = 3'd1;
                w_cs_nxt    = 1'b1;
                w_timer_nxt = r_timer + 1'b1;
            end
            ST_DO_COMPARE: begin
                w_stat_nxt  = 3'd1;
                w_cs_nxt    = 1'b1;
                w_ce_nxt    = 1'b1;
                w_timer_nxt = r_timer + 1'b1;
            end
            ST_DO_RESET: begin
                w_stat_nxt       = 3'd1;
                w_cs_nxt         = 1'b1;
                w_we_nxt         = 1'b1;
                w_rst_nxt        = 1'b1;
                w_rst_or_ini_nxt = 1'b1;
                w_timer_nxt      = r_timer + 1'b1;
            end
            ST_DO_INIT: begin
                w_stat_nxt       = 3'd1;
                w_cs_nxt         = 1'b1;
                w_we_nxt         = 1'b1;
                w_rst_or_ini_nxt = 1'b1;
                w_timer_nxt      = r_timer + 1'b1;
            end
            default: w_stat_nxt = 3'd1;
        endcase

        if (w_igrant) begin
            w_timer_nxt = 1'b0;
        end else begin
            w_timer_nxt = w_timer_nxt;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_READY;
            r_stat       <= 3'd0;
            r_init       <= 1'b0;
            r_rd_dat     <= {N_DATA_BITS{1'b0}};
            r_cs         <= 1'b0;
            r_ce         <= 1'b0;
            r_we         <= 1'b0;
            r_rst        <= 1'b0;
            r_rst_or_ini <= 1'b0;
            r_timer      <= 1'b0;
            r_rst_addr   <= {AW{1'b0}};
            r_sim_tmo    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_stat       <= w_stat_nxt;
            r_init       <= w_init_nxt;
            r_rd_dat     <= w_rd_dat_nxt;
            r_cs         <= w_cs_nxt;
            r_ce         <= w_ce_nxt;
            r_we         <= w_we_nxt;
            r_rst        <= w_rst_nxt;
            r_rst_or_ini <= w_rst_or_ini_nxt;
            r_timer      <= w_timer_nxt;
            r_rst_addr   <= w_rst_addr_nxt;
            r_sim_tmo    <= w_sim_tmo_nxt;
        end
    end

    assign stat_code       = r_stat;
    assign stat_datawords  = 5'd0;
    assign stat_addr       = w_maxaddr;
    assign stat_table_id   = 1'b0;
    assign capability_lst  = CAPABILITIES;
    assign capability_type = MEM_TYPE;
    assign enable          = !r_init;
    assign rd_dat          = r_rd_dat;
    assign sw_cs           = r_cs;
    assign sw_ce           = r_ce;
    assign sw_we           = r_we;
    assign sw_add          = r_rst_or_ini ? r_rst_addr : cmnd_addr;
    assign sw_wdat         = r_rst ? {N_DATA_BITS{1'b0}} : wr_dat;
    assign yield           = r_timer;
    assign reset           = r_rst;

endmodule

// File: tb/tb_indirect_access_ctrl.sv
// Scoreboard bench: a transaction-level model queues expected accesses, status codes and
// read-back values; a negedge monitor pops and compares them as the DUT produces them.
module tb_indirect_access_ctrl;
    localparam logic [10:0] CMND = 11'h454;
    localparam logic [3:0] OP_NOP = 4'd0, OP_READ = 4'd1, OP_WRITE = 4'd2, OP_ENABLE = 4'd3;
    localparam logic [3:0] OP_DISABLE = 4'd4, OP_RESET = 4'd5, OP_INIT = 4'd6, OP_INIT_INC = 4'd7;
    localparam logic [3:0] OP_SET_START = 4'd8, OP_COMPARE = 4'd9, OP_SIM_TMO = 4'd14, OP_ACK = 4'd15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_stb;
    logic [10:0] reg_addr;
    logic [3:0]  cmnd_op;
    logic [4:0]  cmnd_addr;
    logic        cmnd_table_id;
    logic [4:0]  addr_limit;
    logic [31:0] wr_dat, sw_rdat;
    logic        sw_match;
    logic [3:0]  sw_aindex;
    logic        grant;
    logic [2:0]  stat_code;
    logic [4:0]  stat_datawords, stat_addr, sw_add;
    logic        stat_table_id, enable, sw_cs, sw_ce, sw_we, yield, reset;
    logic [15:0] capability_lst;
    logic [3:0]  capability_type;
    logic [31:0] rd_dat, sw_wdat;

    indirect_access_ctrl dut (
        .clk(clk), .rst_n(rst_n), .wr_stb(wr_stb), .reg_addr(reg_addr), .cmnd_op(cmnd_op),
        .cmnd_addr(cmnd_addr), .cmnd_table_id(cmnd_table_id), .addr_limit(addr_limit),
        .wr_dat(wr_dat), .sw_rdat(sw_rdat), .sw_match(sw_match), .sw_aindex(sw_aindex),
        .grant(grant), .stat_code(stat_code), .stat_datawords(stat_datawords),
        .stat_addr(stat_addr), .stat_table_id(stat_table_id), .capability_lst(capability_lst),
        .capability_type(capability_type), .enable(enable), .rd_dat(rd_dat), .sw_cs(sw_cs),
        .sw_ce(sw_ce), .sw_we(sw_we), .sw_add(sw_add), .sw_wdat(sw_wdat), .yield(yield),
        .reset(reset)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic we; logic ce; logic rst; logic [4:0] add; logic [31:0] wdat; } acc_t;
    typedef struct packed { logic [2:0] stat; logic en; logic [4:0] saddr; } st_t;

    acc_t        q_acc[$];
    st_t         q_st[$];
    logic [31:0] q_rd[$];
    int          checks = 0;
    int          failures = 0;
    bit          mon_en = 1'b0;
    logic [2:0]  last_stat;
    logic [31:0] last_rd;

    bit          m_init, m_sim;
    logic [4:0]  m_rst_addr;
    logic [31:0] m_rd;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void exp_acc(logic we, logic ce, logic rst, logic [4:0] add, logic [31:0] wdat);
        acc_t a;
        a = '{we: we, ce: ce, rst: rst, add: add, wdat: wdat};
        q_acc.push_back(a);
    endfunction

    function automatic void exp_stat(logic [2:0] s);
        st_t e;
        e = '{stat: s, en: !m_init, saddr: (m_init ? 5'd0 : addr_limit)};
        q_st.push_back(e);
    endfunction

    function automatic void exp_rd(logic [31:0] v);
        if (v != m_rd) q_rd.push_back(v);
        m_rd = v;
    endfunction

    acc_t        mon_acc;
    st_t         mon_st;
    logic [31:0] mon_rd;

    // Monitor: pops one expectation per observed access, status change or read-back change.
    always @(negedge clk) begin
        if (mon_en) begin
            if (sw_cs === 1'b1) begin
                if (q_acc.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL access_unexpected: got add=%0d we=%0b with none expected", sw_add, sw_we);
                end else begin
                    mon_acc = q_acc.pop_front();
                    check("access", {24'd0, sw_we, sw_ce, reset, sw_add, sw_wdat}, {24'd0, mon_acc});
                end
            end
            if (stat_code !== last_stat) begin
                if (q_st.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL status_unexpected: got stat=%0d with none expected", stat_code);
                end else begin
                    mon_st = q_st.pop_front();
                    check("status", {55'd0, stat_code, enable, stat_addr}, {55'd0, mon_st});
                end
                last_stat <= stat_code;
            end
            if (rd_dat !== last_rd) begin
                if (q_rd.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL rd_dat_unexpected: got %0h with none expected", rd_dat);
                end else begin
                    mon_rd = q_rd.pop_front();
                    check("rd_dat", {32'd0, rd_dat}, {32'd0, mon_rd});
                end
                last_rd <= rd_dat;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input logic [3:0] op, input logic [4:0] a);
        wr_stb = 1'b1; reg_addr = CMND; cmnd_op = op; cmnd_addr = a;
        @(posedge clk);
        #1;
        wr_stb = 1'b0;
    endtask

    // One command from READY: the model predicts the whole transaction, then it is driven.
    task automatic do_cmd(input logic [3:0] op, input logic [4:0] a);
        logic [4:0] maxa, p;
        bit issued, err, eg;
        int n;
        maxa = m_init ? 5'd0 : addr_limit;
        issued = (op != OP_NOP) && (op != OP_SIM_TMO);
        eg = grant && !m_sim;
        err = 1'b0;
        n = 6;
        if (op == OP_SET_START) m_rst_addr = a;
        else if (op == OP_RESET) m_rst_addr = 5'd0;
        if (issued && (a > maxa)) begin
            exp_stat((op >= 4'd10 && op <= 4'd13) ? 3'd5 : 3'd4);
            err = 1'b1;
        end else if (op >= 4'd10 && op <= 4'd13) begin
            exp_stat(3'd5);
            err = 1'b1;
        end else if (op == OP_WRITE || op == OP_READ || op == OP_COMPARE ||
                     op == OP_RESET || op == OP_INIT || op == OP_INIT_INC) begin
            if (!eg) begin
                if (op == OP_WRITE) exp_acc(1'b1, 1'b0, 1'b0, a, wr_dat);
                else if (op == OP_READ) exp_acc(1'b0, 1'b0, 1'b0, a, wr_dat);
                else if (op == OP_COMPARE) exp_acc(1'b0, 1'b1, 1'b0, a, wr_dat);
                else if (op == OP_RESET) exp_acc(1'b1, 1'b0, 1'b1, 5'd0, 32'd0);
                else exp_acc(1'b1, 1'b0, 1'b0, m_rst_addr, wr_dat);
                exp_stat(3'd1); exp_stat(3'd2);
                err = 1'b1;
                m_sim = 1'b0;
            end else begin
                if (op == OP_WRITE) exp_acc(1'b1, 1'b0, 1'b0, a, wr_dat);
                else if (op == OP_READ) exp_acc(1'b0, 1'b0, 1'b0, a, wr_dat);
                else if (op == OP_COMPARE) exp_acc(1'b0, 1'b1, 1'b0, a, wr_dat);
                else if (op == OP_RESET) exp_acc(1'b1, 1'b0, 1'b1, 5'd0, 32'd0);
                else begin
                    p = m_rst_addr;
                    for (int i = 0; i < 32; i++) begin
                        exp_acc(1'b1, 1'b0, 1'b0, p, wr_dat);
                        n++;
                        if (p == a) break;
                        p = p + 5'd1;
                    end
                    m_rst_addr = a + 5'd1;
                end
                exp_stat(3'd1); exp_stat(3'd0);
                if (op == OP_READ) exp_rd(sw_rdat);
                if (op == OP_COMPARE) exp_rd({27'd0, sw_match, sw_aindex});
            end
        end else if (op == OP_SIM_TMO) begin
            m_sim = 1'b1;
        end
        pulse(op, a);
        idle(n);
        if (err) begin
            exp_stat(m_init ? 3'd7 : 3'd0);
            pulse(OP_ACK, 5'd0);
            idle(4);
        end
    endtask

    task automatic op_powerdown(input bit bad);
        logic [4:0] a;
        a = 5'($urandom_range(0, int'(addr_limit)));
        wr_dat = $urandom;
        m_init = 1'b1;
        exp_stat(3'd7);
        exp_rd(wr_dat);
        pulse(OP_DISABLE, a);
        idle(3);
        wr_dat = $urandom;
        exp_rd(wr_dat);
        idle(3);
        if (bad) begin
            exp_stat(3'd4);
            pulse(OP_READ, 5'($urandom_range(1, 31)));
            idle(3);
            exp_stat(3'd7);
            pulse(OP_ACK, 5'd0);
            idle(3);
        end
        m_init = 1'b0;
        exp_stat(3'd0);
        pulse(OP_ENABLE, 5'd0);
        idle(4);
    endtask

    // INIT from s to e, interrupted by a new command after k+1 writes.
    task automatic op_init_abort(input logic [4:0] s, input logic [4:0] e);
        int k;
        do_cmd(OP_SET_START, s);
        k = $urandom_range(0, int'(e - s));
        for (int i = 0; i <= k; i++) exp_acc(1'b1, 1'b0, 1'b0, s + 5'(i), wr_dat);
        exp_stat(3'd1); exp_stat(3'd3);
        pulse(OP_INIT, e);
        idle(k);
        pulse(OP_ACK, e);
        m_rst_addr = s + 5'(k) + 5'd1;
        idle(4);
        exp_stat(3'd0);
        pulse(OP_ACK, 5'd0);
        idle(4);
    endtask

    logic [3:0] ops[10] = '{OP_WRITE, OP_READ, OP_COMPARE, OP_RESET, OP_INIT, OP_INIT_INC,
                            OP_SET_START, OP_NOP, OP_ACK, OP_ENABLE};

    initial begin
        rst_n = 1'b0; wr_stb = 1'b0; reg_addr = CMND; cmnd_op = OP_NOP; cmnd_addr = 5'd9;
        cmnd_table_id = 1'b0; addr_limit = 5'd31; wr_dat = 32'h0; sw_rdat = 32'h0;
        sw_match = 1'b0; sw_aindex = 4'h0; grant = 1'b1;
        m_init = 1'b0; m_sim = 1'b0; m_rst_addr = 5'd0; m_rd = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_stat", {61'd0, stat_code}, 64'd0);
        check("rst_rd_dat", {32'd0, rd_dat}, 64'd0);
        check("rst_enable", {63'd0, enable}, 64'd1);
        check("rst_strobes", {59'd0, sw_cs, sw_ce, sw_we, reset, yield}, 64'd0);
        check("rst_cap_lst", {48'd0, capability_lst}, 64'h8027);
        check("rst_cap_type", {60'd0, capability_type}, 64'h2);
        check("rst_consts", {58'd0, stat_datawords, stat_table_id}, 64'd0);
        check("rst_stat_addr", {59'd0, stat_addr}, {59'd0, addr_limit});
        check("rst_sw_add", {59'd0, sw_add}, {59'd0, cmnd_addr});
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        last_stat = stat_code;
        last_rd = rd_dat;
        mon_en = 1'b1;

        wr_dat = 32'h1234_5678;
        do_cmd(OP_WRITE, 5'd3);
        sw_rdat = 32'hDEAD_BEEF;
        do_cmd(OP_READ, 5'd5);
        addr_limit = 5'd4;
        do_cmd(OP_READ, 5'd7);
        addr_limit = 5'd31;
        do_cmd(OP_SIM_TMO, 5'd0);
        do_cmd(OP_WRITE, 5'd6);
        op_powerdown(1'b1);
        wr_dat = 32'hA5A5_0F0F;
        do_cmd(OP_SET_START, 5'd2);
        do_cmd(OP_INIT, 5'd5);
        do_cmd(4'd11, 5'd1);
        sw_match = 1'b1; sw_aindex = 4'hB;
        do_cmd(OP_COMPARE, 5'd31);
        do_cmd(OP_RESET, 5'd8);
        op_init_abort(5'd4, 5'd12);

        for (int it = 0; it < 200; it++) begin
            int kind;
            addr_limit = ($urandom_range(0, 1) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
            grant = ($urandom_range(0, 7) != 0);
            wr_dat = $urandom; sw_rdat = $urandom;
            sw_match = 1'($urandom_range(0, 1)); sw_aindex = 4'($urandom_range(0, 15));
            kind = $urandom_range(0, 9);
            if (kind <= 4) begin
                do_cmd(ops[$urandom_range(0, 9)], 5'($urandom_range(0, 31)));
            end else if (kind == 5) begin
                do_cmd(OP_SIM_TMO, 5'($urandom_range(0, 31)));
                do_cmd(OP_WRITE, 5'($urandom_range(0, 31)));
            end else if (kind == 6) begin
                do_cmd(4'($urandom_range(10, 13)), 5'($urandom_range(0, 31)));
            end else if (kind == 7) begin
                op_powerdown(1'($urandom_range(0, 1)));
            end else if (kind == 8) begin
                wr_stb = 1'b1;
                reg_addr = CMND ^ 11'($urandom_range(1, 2047));
                cmnd_op = ops[$urandom_range(0, 5)];
                cmnd_addr = 5'($urandom_range(0, 31));
                idle(1);
                wr_stb = 1'b0;
                idle(4);
            end else begin
                logic [4:0] s;
                addr_limit = 5'd31;
                grant = 1'b1;
                s = 5'($urandom_range(0, 20));
                op_init_abort(s, s + 5'($urandom_range(0, 10)));
            end
        end

        idle(6);
        mon_en = 1'b0;
        check("acc_queue_empty", 64'(q_acc.size()), 64'd0);
        check("stat_queue_empty", 64'(q_st.size()), 64'd0);
        check("rd_queue_empty", 64'(q_rd.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
